// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared constants, state encoding and select-vector helpers for the mux16 round-robin arbiter.
// Select vectors are [0:3] with sel[k] carrying index bit k (sel[0] is the LSB).
package mux16_rr_arbiter_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  function automatic logic [SEL_W-1:0] sel_to_idx(input logic [0:SEL_W-1] s);
    logic [SEL_W-1:0] idx;
    for (int k = 0; k < SEL_W; k++) begin
      idx[k] = s[k];
    end
    return idx;
  endfunction

  function automatic logic [0:SEL_W-1] idx_to_sel(input logic [SEL_W-1:0] idx);
    logic [0:SEL_W-1] s;
    for (int k = 0; k < SEL_W; k++) begin
      s[k] = idx[k];
    end
    return s;
  endfunction

endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// Requester-side bus of the mux16 arbiter: request/data vectors in, grant/select/data out.
interface mux16_rr_arbiter_if;
  import mux16_rr_arbiter_pkg::*;

  logic [0:N_REQ-1] req;
  logic [0:N_REQ-1] data_in;
  logic [0:N_REQ-1] grant;
  logic [0:SEL_W-1] sel;
  logic             valid;
  logic             data_out;

  modport master (
    output req,
    output data_in,
    input  grant,
    input  sel,
    input  valid,
    input  data_out
  );

  modport slave (
    input  req,
    input  data_in,
    output grant,
    output sel,
    output valid,
    output data_out
  );

endinterface

// File: rtl/mux16to1.sv
// Existing 16:1 single-bit mux; index = sel[0] + 2*sel[1] + 4*sel[2] + 8*sel[3].
module mux16to1 (
  input  logic [0:15] in,
  input  logic [0:3]  sel,
  output logic        out
);

  assign out = in[{sel[3], sel[2], sel[1], sel[0]}];

endmodule

// File: rtl/rr_pick16.sv
// Circular priority encoder: first set request at or after ptr, wrapping 15 -> 0.
module rr_pick16
  import mux16_rr_arbiter_pkg::*;
(
  input  logic [0:N_REQ-1] req,
  input  logic [0:SEL_W-1] ptr,
  output logic             any,
  output logic [0:SEL_W-1] idx,
  output logic [0:N_REQ-1] onehot
);

  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] pick;

  assign base = sel_to_idx(ptr);
  assign any  = |req;

  always_comb begin
    logic             found;
    logic [SEL_W-1:0] j;
    found = 1'b0;
    pick  = '0;
    j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // 4-bit add wraps naturally past 15.
      j = base + SEL_W'(k);
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = j;
      end
    end
  end

  always_comb begin
    onehot       = '0;
    onehot[pick] = any;
  end

  assign idx = idx_to_sel(pick);

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter with burst limit owning the select of a shared mux16to1.
module mux16_rr_arbiter
  import mux16_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux16_rr_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_BURST - 1);

  state_e           state_q;
  logic [0:N_REQ-1] grant_q;
  logic [0:SEL_W-1] sel_q;
  logic             valid_q;
  logic [0:SEL_W-1] ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic [0:N_REQ-1] cand;
  logic             pick_any;
  logic [0:SEL_W-1] pick_idx;
  logic [0:N_REQ-1] pick_onehot;
  logic [0:SEL_W-1] next_ptr;
  logic             own_req;
  logic             take;
  logic             mux_out;

  // grant_q is zero in idle, so this is req there and "others" while granted.
  assign cand    = bus.req & ~grant_q;
  assign own_req = |(bus.req & grant_q);

  rr_pick16 u_pick (
    .req    (cand),
    .ptr    (ptr_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign next_ptr = idx_to_sel(sel_to_idx(pick_idx) + SEL_W'(1));

  // New owner: first grant from idle, release handoff, or burst-limit handoff.
  assign take = pick_any && ((state_q == StIdle) || !own_req || (cnt_q == CntLast));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else if (take) begin
      state_q <= StGrant;
      grant_q <= pick_onehot;
      sel_q   <= pick_idx;
      valid_q <= 1'b1;
      ptr_q   <= next_ptr;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
        end
        StGrant: begin
          if (!own_req) begin
            state_q <= StIdle;
            grant_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
          end else if (pick_any) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
      endcase
    end
  end

  mux16to1 u_mux (
    .in  (bus.data_in),
    .sel (sel_q),
    .out (mux_out)
  );

  assign bus.grant    = grant_q;
  assign bus.sel      = sel_q;
  assign bus.valid    = valid_q;
  assign bus.data_out = mux_out & valid_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: reference model feeds a scoreboard queue,
// each scenario task pops and compares after every clock edge.
module tb_mux16_rr_arbiter;

  localparam int MB = 4;

  typedef struct packed {
    logic [0:15] grant;
    logic [0:3]  sel;
    logic        valid;
    logic        data_out;
  } obs_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  obs_t sb[$];

  int m_busy, m_owner, m_ptr, m_cnt, m_sel;

  mux16_rr_arbiter_if bus ();

  mux16_rr_arbiter #(
    .MAX_BURST (MB),
    .CNT_W     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [0:15] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  function automatic logic [0:3] sel_of(input int i);
    logic [0:3] s;
    for (int k = 0; k < 4; k++) s[k] = ((i >> k) & 1) != 0;
    return s;
  endfunction

  function automatic logic [0:15] oh_of(input int i);
    logic [0:15] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_sel = 0;
    sb.delete();
  endtask

  task automatic model_step(input logic [0:15] r, input logic [0:15] d);
    logic [0:15] oth;
    int          j;
    obs_t        e;
    if (m_busy == 0) begin
      j = pick(r, m_ptr);
      if (j >= 0) begin
        m_busy = 1; m_owner = j; m_sel = j; m_cnt = 0; m_ptr = (j + 1) % 16;
      end
    end else begin
      oth          = r;
      oth[m_owner] = 1'b0;
      j            = pick(oth, m_ptr);
      if ((!r[m_owner] || m_cnt == MB - 1) && j >= 0) begin
        m_owner = j; m_sel = j; m_cnt = 0; m_ptr = (j + 1) % 16;
      end else if (!r[m_owner]) begin
        m_busy = 0; m_cnt = 0;
      end else begin
        m_cnt = (j >= 0) ? m_cnt + 1 : 0;
      end
    end
    e.grant    = m_busy != 0 ? oh_of(m_owner) : 16'h0000;
    e.sel      = sel_of(m_sel);
    e.valid    = m_busy != 0;
    e.data_out = m_busy != 0 ? d[m_owner] : 1'b0;
    sb.push_back(e);
  endtask

  // Drive one cycle of stimulus, queue its expectation, sample 1 ns after the edge.
  task automatic drive(input logic [0:15] r, input logic [0:15] d);
    bus.req     = r;
    bus.data_in = d;
    model_step(r, d);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.data_in = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.data_in = '1;
    model_reset();
    #3;
    o = {bus.grant, bus.sel, bus.valid, bus.data_out};
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL reset_assert got=%h exp=0", o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(16'h0000, 16'hffff);
      e = sb.pop_front();
      o = {bus.grant, bus.sel, bus.valid, bus.data_out};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_single();
    obs_t        e, o;
    logic [0:15] d;
    for (int i = 0; i < 20; i++) begin
      d    = 16'($urandom());
      d[5] = i[0];
      drive(oh_of(5), d);
      e = sb.pop_front();
      o = {bus.grant, bus.sel, bus.valid, bus.data_out};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL single cyc=%0d got=%h exp=%h", i, o, e);
      end
      if (i == 0) begin
        checks++;
        if (bus.sel !== 4'b1010) begin
          failures++;
          $display("FAIL single_sel got=%b exp=1010", bus.sel);
        end
      end
    end
  endtask

  task automatic test_burst();
    obs_t        e, o;
    logic [0:15] r;
    apply_reset();
    r = oh_of(2) | oh_of(9);
    for (int i = 0; i < 24; i++) begin
      drive(r, 16'($urandom()));
      e = sb.pop_front();
      o = {bus.grant, bus.sel, bus.valid, bus.data_out};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL burst cyc=%0d got=%h exp=%h", i, o, e);
      end
      checks++;
      if (bus.grant !== oh_of(((i / MB) % 2 == 0) ? 2 : 9)) begin
        failures++;
        $display("FAIL burst_owner cyc=%0d got=%h", i, bus.grant);
      end
    end
  endtask

  task automatic test_release();
    obs_t e, o;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive((i < 2) ? (oh_of(3) | oh_of(7)) : oh_of(7), 16'($urandom()));
      e = sb.pop_front();
      o = {bus.grant, bus.sel, bus.valid, bus.data_out};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL release cyc=%0d got=%h exp=%h", i, o, e);
      end
      checks++;
      if (bus.valid !== 1'b1 || bus.grant !== oh_of((i < 2) ? 3 : 7)) begin
        failures++;
        $display("FAIL release_handoff cyc=%0d got=%h valid=%b", i, bus.grant, bus.valid);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    int   own_tbl[3] = '{15, 0, 14};
    apply_reset();
    drive(oh_of(14), 16'h0000);
    void'(sb.pop_front());
    drive(16'h0000, 16'h0000);
    void'(sb.pop_front());
    for (int i = 0; i < 3 * MB; i++) begin
      drive(oh_of(0) | oh_of(14) | oh_of(15), 16'($urandom()));
      e = sb.pop_front();
      o = {bus.grant, bus.sel, bus.valid, bus.data_out};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", i, o, e);
      end
      checks++;
      if (bus.grant !== oh_of(own_tbl[i / MB])) begin
        failures++;
        $display("FAIL wrap_owner cyc=%0d got=%h exp_owner=%0d", i, bus.grant, own_tbl[i / MB]);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t        e, o;
    logic [0:15] d;
    apply_reset();
    d = 16'hffff;
    for (int i = 0; i < 2; i++) begin
      drive(oh_of(9), d);
      e = sb.pop_front();
      o = {bus.grant, bus.sel, bus.valid, bus.data_out};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL areset_pre cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    o = {bus.grant, bus.sel, bus.valid, bus.data_out};
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL areset_mid got=%h exp=0", o);
    end
    model_reset();
    #2;
    rst_n = 1'b1;
    drive(oh_of(9), d);
    e = sb.pop_front();
    o = {bus.grant, bus.sel, bus.valid, bus.data_out};
    checks++;
    if (o !== e || bus.grant !== oh_of(9)) begin
      failures++;
      $display("FAIL areset_regrant got=%h exp=%h", o, e);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.data_in = '0;
    model_reset();
    #2;
    test_reset();
    test_single();
    test_burst();
    test_release();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
